// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access widths, the data segment base,
// arbiter state encoding and the request bundle carried from each port to DataMem.
package dmem_arbiter_pkg;

    localparam logic [1:0]  MEM_BYTE          = 2'b00;
    localparam logic [1:0]  MEM_HALF          = 2'b01;
    localparam logic [1:0]  MEM_WORD          = 2'b10;
    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_2000;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  memop;
        logic        memext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // DATA_BASE_ADDRESS is word-aligned, so the raw low address bits decide alignment.
    function automatic logic is_aligned(input logic [1:0] memop, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        if (memop == MEM_HALF && addr_lo[0])
            ok = 1'b0;
        if (memop == MEM_WORD && addr_lo != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dmem_req_mux.sv
// Combinational winner selection between the two requesters plus the alignment check
// of the winning request.
module dmem_req_mux
    import dmem_arbiter_pkg::*;
(
    input  logic     a_req,
    input  logic     b_req,
    input  logic     force_b,
    input  mem_req_t a_fields,
    input  mem_req_t b_fields,
    output logic     grant,
    output logic     sel_b,
    output mem_req_t sel_req,
    output logic     sel_aligned
);

    always_comb begin
        grant       = a_req | b_req;
        // A has fixed priority; B only wins against a live A request when starving.
        sel_b       = b_req & (~a_req | force_b);
        sel_req     = sel_b ? b_fields : a_fields;
        sel_aligned = is_aligned(sel_req.memop, sel_req.addr[1:0]);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported DataMem: one latched access per
// IDLE -> ACCESS -> RESP pass, fixed priority to A with a starvation escape for B.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             a_req,
    input  logic             a_we,
    input  logic [1:0]       a_memop,
    input  logic             a_memext,
    input  logic [31:0]      a_addr,
    input  logic [31:0]      a_wdata,
    output logic             a_ack,
    output logic             a_err,
    output logic [31:0]      a_rdata,

    input  logic             b_req,
    input  logic             b_we,
    input  logic [1:0]       b_memop,
    input  logic             b_memext,
    input  logic [31:0]      b_addr,
    input  logic [31:0]      b_wdata,
    output logic             b_ack,
    output logic             b_err,
    output logic [31:0]      b_rdata,

    output logic             m_DMWr,
    output logic [1:0]       m_MemOp,
    output logic             m_MemEXT,
    output logic [31:0]      m_address,
    output logic [31:0]      m_din,
    input  logic [31:0]      m_dout,

    output arb_state_t       dbg_state,
    output logic [CNT_W-1:0] dbg_wait_cnt
);

    // Handshake: a requester raises req with stable fields and holds them until its ack;
    // ack is a one-cycle pulse (err qualifies it), and req seen during RESP is ignored.

    arb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             win_b;
    logic             lat_we;
    logic             lat_aligned;

    mem_req_t         a_fields;
    mem_req_t         b_fields;
    mem_req_t         sel_req;
    logic             grant;
    logic             sel_b;
    logic             sel_aligned;
    logic             force_b;

    assign a_fields = '{we: a_we, memop: a_memop, memext: a_memext, addr: a_addr, wdata: a_wdata};
    assign b_fields = '{we: b_we, memop: b_memop, memext: b_memext, addr: b_addr, wdata: b_wdata};
    assign force_b  = (wait_cnt == CNT_W'(MAX_WAIT));

    dmem_req_mux u_req_mux (
        .a_req       (a_req),
        .b_req       (b_req),
        .force_b     (force_b),
        .a_fields    (a_fields),
        .b_fields    (b_fields),
        .grant       (grant),
        .sel_b       (sel_b),
        .sel_req     (sel_req),
        .sel_aligned (sel_aligned)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ARB_IDLE;
            wait_cnt    <= '0;
            win_b       <= 1'b0;
            lat_we      <= 1'b0;
            lat_aligned <= 1'b0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            a_rdata     <= '0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            b_rdata     <= '0;
            m_DMWr      <= 1'b0;
            m_MemOp     <= '0;
            m_MemEXT    <= 1'b0;
            m_address   <= '0;
            m_din       <= '0;
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        win_b       <= sel_b;
                        lat_we      <= sel_req.we;
                        lat_aligned <= sel_aligned;
                        // The memory bus is loaded here so it is valid for the whole ACCESS cycle.
                        m_DMWr      <= sel_req.we & sel_aligned;
                        m_MemOp     <= sel_req.memop;
                        m_MemEXT    <= sel_req.memext;
                        m_address   <= sel_req.addr;
                        m_din       <= sel_req.wdata;
                        state       <= ARB_ACCESS;
                    end
                    if (!b_req || sel_b)
                        wait_cnt <= '0;
                    else if (!force_b)
                        wait_cnt <= wait_cnt + 1'b1;
                end
                ARB_ACCESS: begin
                    m_DMWr    <= 1'b0;
                    m_MemOp   <= '0;
                    m_MemEXT  <= 1'b0;
                    m_address <= '0;
                    m_din     <= '0;
                    if (win_b) begin
                        b_ack <= 1'b1;
                        b_err <= ~lat_aligned;
                        if (!lat_we && lat_aligned)
                            b_rdata <= m_dout;
                    end else begin
                        a_ack <= 1'b1;
                        a_err <= ~lat_aligned;
                        if (!lat_we && lat_aligned)
                            a_rdata <= m_dout;
                    end
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMem attached to the m_* bus.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             a_req, a_we, a_memext;
    logic [1:0]       a_memop;
    logic [31:0]      a_addr, a_wdata;
    logic             a_ack, a_err;
    logic [31:0]      a_rdata;
    logic             b_req, b_we, b_memext;
    logic [1:0]       b_memop;
    logic [31:0]      b_addr, b_wdata;
    logic             b_ack, b_err;
    logic [31:0]      b_rdata;
    logic             m_DMWr, m_MemEXT;
    logic [1:0]       m_MemOp;
    logic [31:0]      m_address, m_din, m_dout;
    arb_state_t       dbg_state;
    logic [CNT_W-1:0] dbg_wait_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_memop(a_memop), .a_memext(a_memext),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_memop(b_memop), .b_memext(b_memext),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .m_DMWr(m_DMWr), .m_MemOp(m_MemOp), .m_MemEXT(m_MemEXT), .m_address(m_address),
        .m_din(m_din), .m_dout(m_dout),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DataMem model ----------------
    logic [7:0]  mem [0:255] = '{default: 8'h00};
    logic [31:0] mem_off;
    logic [7:0]  mi;

    always_comb begin
        mem_off = m_address - DATA_BASE_ADDRESS;
        mi      = mem_off[7:0];
        case (m_MemOp)
            MEM_BYTE: m_dout = {{24{m_MemEXT & mem[mi][7]}}, mem[mi]};
            MEM_HALF: m_dout = {{16{m_MemEXT & mem[8'(mi + 8'd1)][7]}}, mem[8'(mi + 8'd1)], mem[mi]};
            default:  m_dout = {mem[8'(mi + 8'd3)], mem[8'(mi + 8'd2)], mem[8'(mi + 8'd1)], mem[mi]};
        endcase
    end

    always @(posedge clk) begin
        if (m_DMWr) begin
            mem[mi] <= m_din[7:0];
            if (m_MemOp != MEM_BYTE)
                mem[8'(mi + 8'd1)] <= m_din[15:8];
            if (m_MemOp == MEM_WORD) begin
                mem[8'(mi + 8'd2)] <= m_din[23:16];
                mem[8'(mi + 8'd3)] <= m_din[31:24];
            end
        end
    end

    function automatic logic [31:0] mem_word(input logic [7:0] off);
        return {mem[8'(off + 8'd3)], mem[8'(off + 8'd2)], mem[8'(off + 8'd1)], mem[off]};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input bit port, input logic we, input logic [1:0] op,
                             input logic ext, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int wr_cycles);
        bit got;
        @(posedge clk);
        #1;
        if (port) begin
            b_we = we; b_memop = op; b_memext = ext; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_memop = op; a_memext = ext; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        got = 1'b0; lat = 0; wr_cycles = 0; rdata = '0; err = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (m_DMWr) wr_cycles++;
            if (port ? b_ack : a_ack) begin
                got   = 1'b1;
                lat   = i;
                rdata = port ? b_rdata : a_rdata;
                err   = port ? b_err : a_err;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          lat, wrc, n_a;
    bit          b_done;
    logic [31:0] exp;

    initial begin
        rstn = 1'b0;
        a_req = 0; a_we = 0; a_memop = MEM_WORD; a_memext = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_memop = MEM_WORD; b_memext = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("rst_acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_m_dmwr", {31'd0, m_DMWr}, 32'd0);
        check("rst_m_addr", m_address, 32'd0);
        check("rst_cnt", 32'(dbg_wait_cnt), 32'd0);
        rstn = 1'b1;

        // word store then load on A
        do_access(0, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 8, 32'hDEADBEEF, rd, er, lat, wrc);
        check("sw_lat", 32'(lat), 32'd3);
        check("sw_dmwr_cycles", 32'(wrc), 32'd1);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_mem", mem_word(8'd8), 32'hDEADBEEF);
        do_access(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 8, 32'h0, rd, er, lat, wrc);
        check("lw_lat", 32'(lat), 32'd3);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", {31'd0, er}, 32'd0);
        check("lw_no_write", 32'(wrc), 32'd0);

        // byte store and signed / unsigned byte loads
        do_access(0, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 4, 32'h11223344, rd, er, lat, wrc);
        do_access(0, 1, MEM_BYTE, 0, DATA_BASE_ADDRESS + 5, 32'h12345680, rd, er, lat, wrc);
        check("sb_mem", mem_word(8'd4), 32'h11228044);
        do_access(0, 0, MEM_BYTE, 1, DATA_BASE_ADDRESS + 5, 32'h0, rd, er, lat, wrc);
        check("lb_rdata", rd, 32'hFFFFFF80);
        do_access(0, 0, MEM_BYTE, 0, DATA_BASE_ADDRESS + 5, 32'h0, rd, er, lat, wrc);
        check("lbu_rdata", rd, 32'h00000080);
        do_access(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 4, 32'h0, rd, er, lat, wrc);
        check("sb_word_rdata", rd, 32'h11228044);

        // misaligned A half load
        do_access(0, 0, MEM_HALF, 1, DATA_BASE_ADDRESS + 3, 32'h0, rd, er, lat, wrc);
        check("lh_mis_err", {31'd0, er}, 32'd1);
        check("lh_mis_rdata_kept", rd, 32'h11228044);
        check("lh_mis_no_write", 32'(wrc), 32'd0);

        // B alone: store, load, misaligned word store
        do_access(1, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 0, 32'hCAFEF00D, rd, er, lat, wrc);
        check("b_sw_lat", 32'(lat), 32'd3);
        check("b_alone_cnt", 32'(dbg_wait_cnt), 32'd0);
        do_access(1, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 0, 32'h0, rd, er, lat, wrc);
        check("b_lw_rdata", rd, 32'hCAFEF00D);
        do_access(1, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 2, 32'h55555555, rd, er, lat, wrc);
        check("b_sw_mis_err", {31'd0, er}, 32'd1);
        check("b_sw_mis_no_write", 32'(wrc), 32'd0);
        check("b_sw_mis_rdata_kept", rd, 32'hCAFEF00D);
        check("b_sw_mis_mem", mem_word(8'd0), 32'hCAFEF00D);

        // both requesters held: eight A grants, then a forced B grant, then A only
        for (int i = 0; i < MAX_WAIT; i++) exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd0);
        @(posedge clk);
        #1;
        a_we = 0; a_memop = MEM_WORD; a_memext = 0; a_addr = DATA_BASE_ADDRESS + 8;
        b_we = 0; b_memop = MEM_WORD; b_memext = 0; b_addr = DATA_BASE_ADDRESS + 0;
        a_req = 1; b_req = 1;
        n_a = 0; b_done = 0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (a_ack && b_ack) begin
                check("dual_ack", 32'd1, 32'd0);
            end else if (a_ack || b_ack) begin
                exp = exp_q.pop_front();
                check("grant_order", {31'd0, b_ack}, exp);
                if (b_ack) begin
                    b_done = 1;
                    check("cnt_after_b", 32'(dbg_wait_cnt), 32'd0);
                    check("starve_b_rdata", b_rdata, 32'hCAFEF00D);
                    b_req = 0;
                end else if (!b_done) begin
                    n_a++;
                    check("cnt_a_grant", 32'(dbg_wait_cnt), 32'(n_a));
                    check("starve_a_rdata", a_rdata, 32'hDEADBEEF);
                end else begin
                    check("cnt_a_only", 32'(dbg_wait_cnt), 32'd0);
                end
            end
        end
        check("starve_done", 32'(exp_q.size()), 32'd0);
        a_req = 0;
        b_req = 0;

        // reset during the ACCESS cycle of a store
        @(posedge clk);
        @(posedge clk);
        #1;
        a_we = 1; a_memop = MEM_WORD; a_memext = 0; a_addr = DATA_BASE_ADDRESS + 12; a_wdata = 32'h0BADC0DE;
        a_req = 1;
        @(posedge clk);
        #1;
        check("rst_mid_state", 32'(dbg_state), 32'(ARB_ACCESS));
        check("rst_mid_dmwr_pre", {31'd0, m_DMWr}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_dmwr", {31'd0, m_DMWr}, 32'd0);
        check("rst_mid_idle", 32'(dbg_state), 32'(ARB_IDLE));
        check("rst_mid_a_rdata", a_rdata, 32'd0);
        check("rst_mid_b_rdata", b_rdata, 32'd0);
        check("rst_mid_addr", m_address, 32'd0);
        a_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end
        check("rst_mid_mem", mem_word(8'd12), 32'd0);
        rstn = 1'b1;
        do_access(0, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 12, 32'h0BADC0DE, rd, er, lat, wrc);
        check("reissue_lat", 32'(lat), 32'd3);
        check("reissue_err", {31'd0, er}, 32'd0);
        check("reissue_mem", mem_word(8'd12), 32'h0BADC0DE);
        do_access(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 12, 32'h0, rd, er, lat, wrc);
        check("reissue_lw", rd, 32'h0BADC0DE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
